// File: rtl/mux2x1_arbiter.sv
// Round-robin arbiter sharing a 2:1 word mux between two req/ack producers and one valid/ready consumer.
// Optional grant counters (cnt0/cnt1, width CNT_W) are built when MUX_ARB_STATS_EN is defined.
//
// state   | meaning
// --------+-----------------------------------------------
// S_EMPTY | output buffer empty, valid=0
// S_FULL  | output buffer holds an unconsumed word, valid=1
module mux2x1_arbiter #(
   parameter int WIDTH = 32
`ifdef MUX_ARB_STATS_EN
   , parameter int CNT_W = 16
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0,
   input  logic [WIDTH-1:0] e1,
   output logic             ack0,
   input  logic             req1,
   input  logic [WIDTH-1:0] e2,
   output logic             ack1,
   output logic             sel,
   output logic [WIDTH-1:0] salMux,
   output logic             valid,
   input  logic             ready
`ifdef MUX_ARB_STATS_EN
   , output logic [CNT_W-1:0] cnt0,
   output logic [CNT_W-1:0] cnt1
`endif
);

   localparam logic [0:0] S_EMPTY = 1'b0;
   localparam logic [0:0] S_FULL  = 1'b1;

   logic [0:0]       state;
   logic [0:0]       state_nxt;
   logic             last;
   logic             win;
   logic             load;
   logic [WIDTH-1:0] word_mux;

   // On contention the requester not granted most recently wins.
   always_comb begin
      win = req1;
      if (req0 && req1) begin
         win = ~last;
      end
   end

   // Reset gates load so no ack can escape during the reset cycle.
   assign load     = !rst && (req0 || req1) && ((state == S_EMPTY) || ready);
   assign ack0     = load && !win;
   assign ack1     = load && win;
   assign sel      = load ? win : last;
   assign word_mux = sel ? e2 : e1;
   assign valid    = (state == S_FULL);

   always_comb begin
      state_nxt = state;
      case (state)
         S_EMPTY: if (load) state_nxt = S_FULL;
         S_FULL:  if (ready && !load) state_nxt = S_EMPTY;
         default: state_nxt = S_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_EMPTY;
         salMux <= '0;
         last   <= 1'b1;
      end else begin
         state <= state_nxt;
         if (load) begin
            salMux <= word_mux;
            last   <= win;
         end
      end
   end

`ifdef MUX_ARB_STATS_EN
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt0 <= '0;
         cnt1 <= '0;
      end else begin
         if (ack0 && (cnt0 != '1)) cnt0 <= cnt0 + CNT_ONE;
         if (ack1 && (cnt1 != '1)) cnt1 <= cnt1 + CNT_ONE;
      end
   end
`endif

endmodule

// File: tb/tb_mux2x1_arbiter.sv
// Self-checking bench for mux2x1_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level model of the arbiter.
module tb_mux2x1_arbiter;

   localparam int WIDTH   = 32;
   localparam int CNT_W   = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             req0, req1, ready;
   logic [WIDTH-1:0] e1, e2;
   logic             ack0, ack1, sel, valid;
   logic [WIDTH-1:0] salMux;
`ifdef MUX_ARB_STATS_EN
   logic [CNT_W-1:0] cnt0, cnt1;
`endif

   int checks = 0;
   int errors = 0;

   // model state: buffered word, who was granted last, grant tallies
   bit               m_valid;
   logic [WIDTH-1:0] m_data;
   int               m_last;
   int               m_cnt0, m_cnt1;
   bit               m_load;
   int               m_win;
   bit               exp_ack0, exp_ack1, exp_sel;

   mux2x1_arbiter #(
      .WIDTH(WIDTH)
`ifdef MUX_ARB_STATS_EN
      , .CNT_W(CNT_W)
`endif
   ) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .e1(e1), .ack0(ack0),
      .req1(req1), .e2(e2), .ack1(ack1),
      .sel(sel), .salMux(salMux), .valid(valid), .ready(ready)
`ifdef MUX_ARB_STATS_EN
      , .cnt0(cnt0), .cnt1(cnt1)
`endif
   );

   always #5 clk = ~clk;

   function automatic void predict();
      m_load = !rst && (req0 || req1) && (!m_valid || ready);
      if (req0 && req1) m_win = (m_last == 0) ? 1 : 0;
      else              m_win = req1 ? 1 : 0;
      exp_ack0 = m_load && (m_win == 0);
      exp_ack1 = m_load && (m_win == 1);
      exp_sel  = m_load ? (m_win == 1) : (m_last == 1);
   endfunction

   function automatic void commit();
      if (rst) begin
         m_valid = 0; m_data = '0; m_last = 1; m_cnt0 = 0; m_cnt1 = 0;
      end else if (m_load) begin
         m_data  = (m_win == 1) ? e2 : e1;
         m_valid = 1;
         m_last  = m_win;
         if (m_win == 0 && m_cnt0 < CNT_MAX) m_cnt0++;
         if (m_win == 1 && m_cnt1 < CNT_MAX) m_cnt1++;
      end else if (ready) begin
         m_valid = 0;
      end
   endfunction

   task automatic settle();
      #1;
      predict();
   endtask

   task automatic tick();
      @(posedge clk);
      commit();
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1; req0 = 0; req1 = 0; ready = 1;
      settle();
      tick();
      @(negedge clk);
      rst = 0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1; req0 = 1; req1 = 1; ready = 1; e1 = $urandom; e2 = $urandom;
      for (int i = 0; i < 2; i++) begin
         if (i > 0) @(negedge clk);
         settle();
         checks++;
         if (ack0 !== 1'b0 || ack1 !== 1'b0) begin
            errors++; $display("FAIL reset_ack cyc%0d ack0=%b ack1=%b want 0 0", i, ack0, ack1);
         end
         tick();
      end
      checks++;
      if (valid !== 1'b0 || salMux !== '0) begin
         errors++; $display("FAIL reset_out valid=%b salMux=%h want 0 00000000", valid, salMux);
      end
      @(negedge clk);
      rst = 0; req0 = 0; req1 = 0;
      settle();
      checks++;
      if (sel !== 1'b1) begin
         errors++; $display("FAIL reset_sel sel=%b want 1", sel);
      end
      tick();
   endtask

   task automatic test_single();
      do_reset();
      req0 = 1; req1 = 0; e1 = 32'hAAAAAAAA; ready = 1;
      settle();
      checks++;
      if (ack0 !== 1'b1 || ack1 !== 1'b0 || sel !== 1'b0) begin
         errors++; $display("FAIL single_grant ack0=%b ack1=%b sel=%b want 1 0 0", ack0, ack1, sel);
      end
      tick();
      checks++;
      if (valid !== 1'b1 || salMux !== 32'hAAAAAAAA) begin
         errors++; $display("FAIL single_data valid=%b salMux=%h want 1 aaaaaaaa", valid, salMux);
      end
      @(negedge clk);
      req0 = 0;
      settle();
      tick();
      checks++;
      if (valid !== 1'b0) begin
         errors++; $display("FAIL single_drain valid=%b want 0", valid);
      end
   endtask

   task automatic test_alternate();
      logic [WIDTH-1:0] want;
      do_reset();
      req0 = 1; req1 = 1; e1 = 32'h12345678; e2 = 32'h87654321; ready = 1;
      for (int i = 0; i < 6; i++) begin
         if (i > 0) @(negedge clk);
         settle();
         checks++;
         if (ack0 !== ((i % 2) == 0) || ack1 !== ((i % 2) == 1) || ack0 !== exp_ack0 || sel !== exp_sel) begin
            errors++; $display("FAIL alt_ack cyc%0d ack0=%b ack1=%b sel=%b want %b %b %b",
                               i, ack0, ack1, sel, exp_ack0, exp_ack1, exp_sel);
         end
         tick();
         want = ((i % 2) == 0) ? 32'h12345678 : 32'h87654321;
         checks++;
         if (valid !== 1'b1 || salMux !== want) begin
            errors++; $display("FAIL alt_data cyc%0d valid=%b salMux=%h want 1 %h", i, valid, salMux, want);
         end
      end
      @(negedge clk);
      req0 = 0; req1 = 0;
   endtask

   task automatic test_backpressure();
      logic [WIDTH-1:0] nxt;
      do_reset();
      req0 = 1; req1 = 0; e1 = 32'h55555555; ready = 1;
      settle();
      tick();
      nxt = $urandom;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         req0 = 0; req1 = 1; e2 = nxt; ready = 0;
         settle();
         checks++;
         if (ack1 !== 1'b0 || ack0 !== 1'b0) begin
            errors++; $display("FAIL bp_ack cyc%0d ack0=%b ack1=%b want 0 0", i, ack0, ack1);
         end
         tick();
         checks++;
         if (valid !== 1'b1 || salMux !== 32'h55555555) begin
            errors++; $display("FAIL bp_hold cyc%0d valid=%b salMux=%h want 1 55555555", i, valid, salMux);
         end
      end
      @(negedge clk);
      ready = 1;
      settle();
      checks++;
      if (ack1 !== 1'b1 || sel !== 1'b1) begin
         errors++; $display("FAIL bp_release ack1=%b sel=%b want 1 1", ack1, sel);
      end
      tick();
      checks++;
      if (valid !== 1'b1 || salMux !== nxt) begin
         errors++; $display("FAIL bp_newword valid=%b salMux=%h want 1 %h", valid, salMux, nxt);
      end
      @(negedge clk);
      req1 = 0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      req0 = 1; req1 = 1; e1 = $urandom; e2 = $urandom; ready = 1;
      settle();
      tick();
      tick();
      @(negedge clk);
      rst = 1;
      settle();
      checks++;
      if (ack0 !== 1'b0 || ack1 !== 1'b0) begin
         errors++; $display("FAIL rstmid_ack ack0=%b ack1=%b want 0 0", ack0, ack1);
      end
      tick();
      checks++;
      if (valid !== 1'b0) begin
         errors++; $display("FAIL rstmid_valid valid=%b want 0", valid);
      end
      @(negedge clk);
      rst = 0;
      settle();
      checks++;
      if (ack0 !== 1'b1 || ack1 !== 1'b0) begin
         errors++; $display("FAIL rstmid_first ack0=%b ack1=%b want 1 0", ack0, ack1);
      end
      tick();
      @(negedge clk);
      req0 = 0; req1 = 0;
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         rst   = ($urandom_range(0, 49) == 0);
         req0  = $urandom_range(0, 3) != 0;
         req1  = $urandom_range(0, 3) != 0;
         ready = $urandom_range(0, 3) != 0;
         e1    = $urandom;
         e2    = $urandom;
         settle();
         checks++;
         if (ack0 !== exp_ack0 || ack1 !== exp_ack1 || (!rst && sel !== exp_sel)) begin
            errors++; $display("FAIL rand_ctl cyc%0d ack0=%b ack1=%b sel=%b want %b %b %b",
                               i, ack0, ack1, sel, exp_ack0, exp_ack1, exp_sel);
         end
         tick();
         checks++;
         if (valid !== m_valid || (m_valid && salMux !== m_data)) begin
            errors++; $display("FAIL rand_out cyc%0d valid=%b salMux=%h want %b %h",
                               i, valid, salMux, m_valid, m_data);
         end
`ifdef MUX_ARB_STATS_EN
         checks++;
         if (int'(cnt0) != m_cnt0 || int'(cnt1) != m_cnt1) begin
            errors++; $display("FAIL rand_cnt cyc%0d cnt0=%0d cnt1=%0d want %0d %0d",
                               i, cnt0, cnt1, m_cnt0, m_cnt1);
         end
`endif
      end
      @(negedge clk);
      rst = 0; req0 = 0; req1 = 0;
   endtask

`ifdef MUX_ARB_STATS_EN
   task automatic test_stats();
      do_reset();
      req0 = 1; req1 = 0; ready = 1;
      for (int i = 0; i < 20; i++) begin
         if (i > 0) @(negedge clk);
         e1 = $urandom;
         settle();
         tick();
      end
      checks++;
      if (cnt0 !== 4'hF || cnt1 !== 4'h0) begin
         errors++; $display("FAIL stats_sat cnt0=%h cnt1=%h want f 0", cnt0, cnt1);
      end
      @(negedge clk);
      req0 = 0;
   endtask
`endif

   initial begin
      rst = 1; req0 = 0; req1 = 0; ready = 0; e1 = '0; e2 = '0;
      m_valid = 0; m_data = '0; m_last = 1; m_cnt0 = 0; m_cnt1 = 0;
      test_reset();
      test_single();
      test_alternate();
      test_backpressure();
      test_reset_mid();
      test_random();
`ifdef MUX_ARB_STATS_EN
      test_stats();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
